// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: default widths, opcode
// constants, accumulator source encoding, FSM state type and the bundle of
// decoded control signals.
package bip_pkg;

  localparam int PC_W_DEF  = 11;
  localparam int OPC_W_DEF = 5;

  // Opcodes
  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  // Accumulator source select
  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu_op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(7'b0000000);

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: turns an opcode into the datapath control
// bundle and flags the halt instruction. Unknown opcodes decode as NOP.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic [OPC_W-1:0] i_opc,
  output ctrl_t            o_ctrl,
  output logic             o_is_hlt
);

  // Opcode to control-signal lookup
  always_comb begin
    o_ctrl   = CTRL_NONE;
    o_is_hlt = 1'b0;
    case (i_opc)
      OPC_W'(OP_HLT): begin
        o_is_hlt = 1'b1;
      end
      OPC_W'(OP_STO): begin
        o_ctrl.wr_ram = 1'b1;
      end
      OPC_W'(OP_LD): begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SEL_A_MEM;
      end
      OPC_W'(OP_LDI): begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SEL_A_IMM;
      end
      OPC_W'(OP_ADD): begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SEL_A_ALU;
        o_ctrl.sel_b  = 1'b0;
        o_ctrl.alu_op = 1'b1;
      end
      OPC_W'(OP_ADDI): begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SEL_A_ALU;
        o_ctrl.sel_b  = 1'b1;
        o_ctrl.alu_op = 1'b1;
      end
      OPC_W'(OP_SUB): begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SEL_A_ALU;
        o_ctrl.sel_b  = 1'b0;
        o_ctrl.alu_op = 1'b0;
      end
      OPC_W'(OP_SUBI): begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SEL_A_ALU;
        o_ctrl.sel_b  = 1'b1;
        o_ctrl.alu_op = 1'b0;
      end
      default: begin
        o_ctrl   = CTRL_NONE;
        o_is_hlt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: IDLE/FETCH/EXEC/HALT sequencer with program counter and
// instruction register. Control outputs are registered; they are loaded at
// the edge that enters EXEC (together with the instruction register) so they
// are valid for exactly the EXEC cycle. halted rises in the EXEC cycle of a
// HLT and stays high in HALT until rst.
// Optional feature: define BIP_CONTROL_CYCLE_CNT_EN to add a saturating
// 32-bit cycle_count output counting FETCH and EXEC cycles.
module bip_control
  import bip_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OPC_W+PC_W-1:0] instr,
  output logic [PC_W-1:0]       pc_addr,
  output logic [PC_W-1:0]       operand,
  output logic [1:0]            sel_a,
  output logic                  sel_b,
  output logic                  alu_op,
  output logic                  wr_acc,
  output logic                  wr_ram,
  output logic                  rd_ram,
  output logic                  halted
`ifdef BIP_CONTROL_CYCLE_CNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t                  r_state;
  logic [PC_W-1:0]         r_pc;
  logic [OPC_W+PC_W-1:0]   r_ir;
  ctrl_t                   r_ctrl;
  logic                    r_halted;

  ctrl_t                   w_ctrl;
  logic                    w_is_hlt;
  logic                    w_ir_hlt;

  bip_decoder #(
    .OPC_W (OPC_W)
  ) u_decoder (
    .i_opc    (instr[OPC_W+PC_W-1:PC_W]),
    .o_ctrl   (w_ctrl),
    .o_is_hlt (w_is_hlt)
  );

  assign w_ir_hlt = (r_ir[OPC_W+PC_W-1:PC_W] == OPC_W'(OP_HLT));

  // Sequencer, PC, instruction register and registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_ctrl   <= CTRL_NONE;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ctrl   <= CTRL_NONE;
          r_halted <= 1'b0;
          if (start) begin
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Latch the word addressed during FETCH and its decode together
          r_ir     <= instr;
          r_ctrl   <= w_ctrl;
          r_halted <= w_is_hlt;
          r_state  <= ST_EXEC;
        end
        ST_EXEC: begin
          r_ctrl <= CTRL_NONE;
          if (w_ir_hlt) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else begin
            r_halted <= 1'b0;
            r_pc     <= r_pc + PC_ONE;
            r_state  <= ST_FETCH;
          end
        end
        ST_HALT: begin
          r_ctrl   <= CTRL_NONE;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_ctrl   <= CTRL_NONE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign pc_addr = r_pc;
  assign operand = r_ir[PC_W-1:0];
  assign sel_a   = r_ctrl.sel_a;
  assign sel_b   = r_ctrl.sel_b;
  assign alu_op  = r_ctrl.alu_op;
  assign wr_acc  = r_ctrl.wr_acc;
  assign wr_ram  = r_ctrl.wr_ram;
  assign rd_ram  = r_ctrl.rd_ram;
  assign halted  = r_halted;

`ifdef BIP_CONTROL_CYCLE_CNT_EN
  logic [31:0] r_cycle_cnt;

  // Count active (FETCH/EXEC) cycles, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= 32'd0;
    end else if (((r_state == ST_FETCH) || (r_state == ST_EXEC)) &&
                 (r_cycle_cnt != 32'hFFFF_FFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end else begin
      r_cycle_cnt <= r_cycle_cnt;
    end
  end

  assign cycle_count = r_cycle_cnt;
`endif

endmodule

// File: doc/bip_control.md
BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 Parameter PC_W, default 11, sets the program-counter and operand width.
REQ-002 Parameter OPC_W, default 5, sets the opcode width; instruction width is OPC_W+PC_W (16).
REQ-003 Port list:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching at PC=0.
- instr  in  OPC_W+PC_W  program-memory read data, valid one cycle after pc_addr is presented.
- pc_addr  out  PC_W  program-memory address (the PC).
- operand  out  PC_W  low PC_W bits of the latched instruction.
- sel_a  out  2  accumulator source: 0 = data memory, 1 = immediate, 2 = ALU result.
- sel_b  out  1  ALU B source: 0 = data memory, 1 = immediate.
- alu_op  out  1  ALU operation to the datapath ALU: 1 = add, 0 = subtract.
- wr_acc  out  1  accumulator write strobe.
- wr_ram  out  1  data-memory write strobe.
- rd_ram  out  1  data-memory read strobe.
- halted  out  1  high while in HALT.

Function
REQ-004 FSM states are IDLE, FETCH, EXEC and HALT; rst forces IDLE.
REQ-005 IDLE: all strobes are 0 and pc_addr=0; start=1 moves to FETCH next cycle.
REQ-006 FETCH: pc_addr holds the PC for one cycle; all strobes are 0; next state is EXEC.
REQ-007 EXEC: instr is latched into an instruction register on entry; control outputs decode from that register for exactly one cycle.
REQ-008 Fetch-to-strobe latency is 2 cycles per instruction: FETCH, then EXEC.
REQ-009 Decode table (opcode: strobes asserted, selects):
- HLT 00000: none.
- STO 00001: wr_ram.
- LD 00010: rd_ram, wr_acc, sel_a=0.
- LDI 00011: wr_acc, sel_a=1.
- ADD 00100: rd_ram, wr_acc, sel_a=2, sel_b=0, alu_op=1.
- ADDI 00101: wr_acc, sel_a=2, sel_b=1, alu_op=1.
- SUB 00110: rd_ram, wr_acc, sel_a=2, sel_b=0, alu_op=0.
- SUBI 00111: wr_acc, sel_a=2, sel_b=1, alu_op=0.
REQ-010 Any other opcode is a NOP: no strobes asserted, PC advances.
REQ-011 After a non-HLT EXEC, PC increments by 1 modulo 2^PC_W (2047 wraps to 0) and the FSM returns to FETCH.
REQ-012 HLT in EXEC moves to HALT and leaves the PC unchanged; HALT asserts halted=1, all strobes 0, and is left only by rst.
REQ-013 start is ignored outside IDLE.
REQ-014 Outside EXEC: sel_a=0, sel_b=0, alu_op=0, operand holds its last latched value.

Reset
REQ-015 rst=1 at any cycle, including mid-EXEC, sets IDLE, PC=0, instruction register=0, all outputs 0 and halted=0 at the next edge; strobes in the reset cycle's successor are 0.
REQ-016 rst has priority over start and over every FSM transition.

Configuration
REQ-017 Macro BIP_CONTROL_CYCLE_CNT_EN defined: adds output cycle_count (32 bits), cleared by rst, incremented every cycle in FETCH or EXEC, frozen in IDLE and HALT, saturating at 2^32-1.
REQ-018 Macro undefined: the cycle_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-019 Shared package bip_pkg holds the opcode constants, the sel_a encoding constants, the FSM state typedef and the default PC_W/OPC_W values.
REQ-020 Combinational sub-module bip_decoder maps opcode to {sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram}; bip_control holds the FSM, PC and instruction register.

Verification
REQ-021 The bench shall cover:
- rst, then start pulse, program {LDI 5, ADDI 3, HLT}: wr_acc on cycles 3 and 5 with sel_a=1 then 2/sel_b=1/alu_op=1; halted=1 from cycle 7; pc_addr stays 2.
- Program {LD 10, SUB 11, STO 12, HLT}: rd_ram+wr_acc, rd_ram+wr_acc with alu_op=0, then wr_ram with operand=12.
- Opcode 11111 at address 0: no strobes, PC advances to 1.
- PC preloaded near the top with NOPs: address 2047 is fetched, then pc_addr=0.
- rst asserted during EXEC of ADD: strobes 0 next cycle, state IDLE, pc_addr=0; start pulses while in HALT are ignored.
- With BIP_CONTROL_CYCLE_CNT_EN, the 3-instruction program gives cycle_count=6, which holds in HALT.
